// File: rtl/trap_ctrl_pkg.sv
// Shared constants, state encoding and mstatus update helpers for the
// machine-mode trap sequencer.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int CAUSE_W = 31;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_W_MEPC    = 3'd1,
    ST_W_MCAUSE  = 3'd2,
    ST_W_MSTATUS = 3'd3,
    ST_W_MRET    = 3'd4,
    ST_JUMP      = 3'd5
  } state_e;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / mret sequencer at the MEM/WB boundary. Issues one
// CSR write per cycle through the single CSR write port, then redirects the PC.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [11:0] MEPC_ADDR    = CSR_MEPC,
  parameter logic [11:0] MCAUSE_ADDR  = CSR_MCAUSE,
  parameter logic [11:0] MSTATUS_ADDR = CSR_MSTATUS
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 Interrupt,
  input  logic [CAUSE_W-1:0]   Exception_code,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_pc,
  input  logic                 mem_exc,
  input  logic [CAUSE_W-1:0]   mem_exc_code,
  input  logic                 mem_is_mret,
  input  logic [31:0]          csr_mstatus,
  input  logic [31:0]          csr_mtvec,
  input  logic [31:0]          csr_mepc,
  output logic                 csr_we,
  output logic [11:0]          csr_waddr,
  output logic [31:0]          csr_wdata,
  output logic                 stall_req,
  output logic                 flush,
  output logic [31:0]          new_pc,
  output logic                 trap_ack
);

  state_e      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] ret_pc_q, ret_pc_d;
  logic        is_irq_q, is_irq_d;
  logic        is_ret_q, is_ret_d;

  logic        csr_we_q, csr_we_d;
  logic [11:0] csr_waddr_q, csr_waddr_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic        stall_q, stall_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        trap_ack_q, trap_ack_d;

  logic        trigger_s;
  logic [31:0] tvec_base_s;
  logic [31:0] tvec_vec_s;

  // Next-state and capture logic; triggers are only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    cause_d   = cause_q;
    mstatus_d = mstatus_q;
    ret_pc_d  = ret_pc_q;
    is_irq_d  = is_irq_q;
    is_ret_d  = is_ret_q;
    trigger_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid && Interrupt) begin
          trigger_s = 1'b1;
          epc_d     = mem_pc;
          cause_d   = {1'b1, Exception_code};
          is_irq_d  = 1'b1;
          is_ret_d  = 1'b0;
          mstatus_d = csr_mstatus;
          state_d   = ST_W_MEPC;
        end else if (mem_valid && mem_exc) begin
          trigger_s = 1'b1;
          epc_d     = mem_pc;
          cause_d   = {1'b0, mem_exc_code};
          is_irq_d  = 1'b0;
          is_ret_d  = 1'b0;
          mstatus_d = csr_mstatus;
          state_d   = ST_W_MEPC;
        end else if (mem_valid && mem_is_mret) begin
          trigger_s = 1'b1;
          is_irq_d  = 1'b0;
          is_ret_d  = 1'b1;
          mstatus_d = csr_mstatus;
          ret_pc_d  = csr_mepc;
          state_d   = ST_W_MRET;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_W_MEPC:    state_d = ST_W_MCAUSE;
      ST_W_MCAUSE:  state_d = ST_W_MSTATUS;
      ST_W_MSTATUS: state_d = ST_JUMP;
      ST_W_MRET:    state_d = ST_JUMP;
      ST_JUMP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  assign tvec_base_s = {csr_mtvec[31:2], 2'b00};
  // cause[30:0] << 2 truncated to 32 bits keeps only cause[29:0].
  assign tvec_vec_s  = tvec_base_s + {cause_q[29:0], 2'b00};

  // Outputs are computed for the state being entered so they register in-step.
  always_comb begin
    csr_we_d    = 1'b0;
    csr_waddr_d = 12'h000;
    csr_wdata_d = 32'h0000_0000;
    flush_d     = 1'b0;
    new_pc_d    = 32'h0000_0000;
    trap_ack_d  = 1'b0;
    stall_d     = (state_d != ST_IDLE);
    case (state_d)
      ST_W_MEPC: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = MEPC_ADDR;
        csr_wdata_d = epc_d;
      end
      ST_W_MCAUSE: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = MCAUSE_ADDR;
        csr_wdata_d = cause_d;
      end
      ST_W_MSTATUS: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = MSTATUS_ADDR;
        csr_wdata_d = trap_mstatus(mstatus_d);
      end
      ST_W_MRET: begin
        csr_we_d    = 1'b1;
        csr_waddr_d = MSTATUS_ADDR;
        csr_wdata_d = mret_mstatus(mstatus_d);
      end
      ST_JUMP: begin
        flush_d    = 1'b1;
        trap_ack_d = ~is_ret_q;
        if (is_ret_q) begin
          new_pc_d = ret_pc_q;
        end else if ((csr_mtvec[1:0] == 2'b01) && is_irq_q) begin
          new_pc_d = tvec_vec_s;
        end else begin
          new_pc_d = tvec_base_s;
        end
      end
      default: begin
        csr_we_d = 1'b0;
      end
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= ST_IDLE;
      epc_q       <= 32'h0000_0000;
      cause_q     <= 32'h0000_0000;
      mstatus_q   <= 32'h0000_0000;
      ret_pc_q    <= 32'h0000_0000;
      is_irq_q    <= 1'b0;
      is_ret_q    <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_waddr_q <= 12'h000;
      csr_wdata_q <= 32'h0000_0000;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
      new_pc_q    <= 32'h0000_0000;
      trap_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      mstatus_q   <= mstatus_d;
      ret_pc_q    <= ret_pc_d;
      is_irq_q    <= is_irq_d;
      is_ret_q    <= is_ret_d;
      csr_we_q    <= csr_we_d;
      csr_waddr_q <= csr_waddr_d;
      csr_wdata_q <= csr_wdata_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
      new_pc_q    <= new_pc_d;
      trap_ack_q  <= trap_ack_d;
    end
  end

  assign csr_we    = csr_we_q;
  assign csr_waddr = csr_waddr_q;
  assign csr_wdata = csr_wdata_q;
  assign stall_req = stall_q | trigger_s;
  assign flush     = flush_q;
  assign new_pc    = new_pc_q;
  assign trap_ack  = trap_ack_q;

endmodule
